// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID/EX/WB hazard inputs and IF/ID/EX control outputs of the hazard sequencer
//   id_*          ID-stage instruction: valid, sources, destination, ret/halt decode
//   ex_redirect   EX taken branch/call this cycle
//   ret_done      return PC valid at IF (pulse)
//   wb_*          register-file write from WB
//   stall_if/stall_id/bubble_ex/flush_ifid/halted   pipeline control outputs
//   perf_*        stall/flush event counters, present only with HAZARD_PERF_CNT_EN
interface pipe_hazard_ctrl_if #(parameter int REG_W = 4);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_writes_rd;
    logic [REG_W-1:0] id_rd;
    logic             id_is_ret;
    logic             id_is_halt;
    logic             ex_redirect;
    logic             ret_done;
    logic             wb_reg_write;
    logic [REG_W-1:0] wb_rd;
    logic             stall_if;
    logic             stall_id;
    logic             bubble_ex;
    logic             flush_ifid;
    logic             halted;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0]      perf_stall_cnt;
    logic [15:0]      perf_flush_cnt;
`endif
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_writes_rd, id_rd,
               id_is_ret, id_is_halt, ex_redirect, ret_done, wb_reg_write, wb_rd,
`ifdef HAZARD_PERF_CNT_EN
        input  perf_stall_cnt, perf_flush_cnt,
`endif
        input  stall_if, stall_id, bubble_ex, flush_ifid, halted
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_writes_rd, id_rd,
               id_is_ret, id_is_halt, ex_redirect, ret_done, wb_reg_write, wb_rd,
`ifdef HAZARD_PERF_CNT_EN
        output perf_stall_cnt, perf_flush_cnt,
`endif
        output stall_if, stall_id, bubble_ex, flush_ifid, halted
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-based stall/flush sequencer for the 5-stage pipeline
//   clk, rst   clock, synchronous active-high reset
//   hz         pipe_hazard_ctrl_if.slave: ID/EX/WB hazard inputs, stall/flush/halt outputs
//   Optional HAZARD_PERF_CNT_EN adds hz.perf_stall_cnt / hz.perf_flush_cnt event counters.
module pipe_hazard_ctrl #(
    parameter int NUM_REGS   = 16,
    parameter int REG_W      = 4,
    parameter int CNT_W      = 2,
    parameter int PIPE_DEPTH = 3
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, RET_WAIT, DRAIN, HALTED} state_t;
    state_t                r_state, w_next;
    logic [CNT_W-1:0]      r_pend [NUM_REGS];
    logic [PIPE_DEPTH-1:0] r_issue_sr;
    logic [NUM_REGS-1:0]   w_up, w_dn;
    logic                  w_hazard, w_issue, w_inc, w_dec, w_pend_zero, w_redir, w_hz_stall;

    assign w_hazard = hz.id_valid &
                      ((hz.id_uses_rs & (r_pend[hz.id_rs] != '0) & (hz.id_rs != '0)) |
                       (hz.id_uses_rt & (r_pend[hz.id_rt] != '0) & (hz.id_rt != '0)));
    assign w_issue    = hz.id_valid & ~w_hazard & ~hz.ex_redirect & (r_state == RUN);
    assign w_inc      = w_issue & hz.id_writes_rd & (hz.id_rd != '0);
    assign w_dec      = hz.wb_reg_write & (hz.wb_rd != '0);
    // A redirect in RET_WAIT is ignored and HALTED exits only through reset.
    assign w_redir    = hz.ex_redirect & ((r_state == RUN) | (r_state == DRAIN));
    assign w_hz_stall = (r_state == RUN) & ~hz.ex_redirect & w_hazard;

    always_comb begin
        w_up = '0;
        w_dn = '0;
        w_up[hz.id_rd] = w_inc;
        w_dn[hz.wb_rd] = w_dec;
        w_pend_zero = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) if (r_pend[i] != '0) w_pend_zero = 1'b0;
    end

    // Counters saturate; a simultaneous increment and decrement cancels.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++)
            if (rst) r_pend[i] <= '0;
            else if (w_up[i] && !w_dn[i] && r_pend[i] != '1) r_pend[i] <= r_pend[i] + 1'b1;
            else if (w_dn[i] && !w_up[i] && r_pend[i] != '0) r_pend[i] <= r_pend[i] - 1'b1;
        r_issue_sr <= rst ? '0 : {r_issue_sr[PIPE_DEPTH-2:0], w_issue};
        r_state    <= rst ? RUN : w_next;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk)
        if (!rst)
            for (int i = 0; i < NUM_REGS; i++) begin
                assert (!(w_up[i] && !w_dn[i] && r_pend[i] == '1)) else $error("pend overflow r%0d", i);
                assert (!(w_dn[i] && !w_up[i] && r_pend[i] == '0)) else $error("pend underflow r%0d", i);
            end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN:      w_next = (w_issue & hz.id_is_ret & ~hz.ret_done) ? RET_WAIT :
                               (w_issue & hz.id_is_halt) ? DRAIN : RUN;
            RET_WAIT: w_next = hz.ret_done ? RUN : RET_WAIT;
            DRAIN:    w_next = (r_issue_sr == '0 && w_pend_zero) ? HALTED : DRAIN;
            default:  w_next = HALTED;
        endcase
    end

    always_comb begin
        hz.stall_if   = 1'b0;
        hz.stall_id   = 1'b0;
        hz.bubble_ex  = 1'b0;
        hz.flush_ifid = 1'b0;
        hz.halted     = 1'b0;
        if (rst) begin
        end else if (r_state == HALTED) begin
            hz.stall_if  = 1'b1;
            hz.stall_id  = 1'b1;
            hz.bubble_ex = 1'b1;
            hz.halted    = 1'b1;
        end else if (w_redir) begin
            hz.flush_ifid = 1'b1;
            hz.bubble_ex  = 1'b1;
        end else if (r_state != RUN) begin
            hz.stall_if   = 1'b1;
            hz.flush_ifid = 1'b1;
        end else if (w_hazard) begin
            hz.stall_if  = 1'b1;
            hz.stall_id  = 1'b1;
            hz.bubble_ex = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk)
        if (rst) begin
            hz.perf_stall_cnt <= '0;
            hz.perf_flush_cnt <= '0;
        end else if (r_state != HALTED) begin
            hz.perf_stall_cnt <= hz.perf_stall_cnt + {15'd0, w_hz_stall};
            hz.perf_flush_cnt <= hz.perf_flush_cnt + {15'd0, hz.ex_redirect};
        end
`else
    logic w_unused;
    assign w_unused = w_hz_stall;
`endif
endmodule
